// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl -- sequencer for a Goldschmidt floating-point divide datapath.
//
// A divide is accepted in IDLE when start is high. The operands are latched
// and held for the datapath. The controller then steps through:
//   NUM0 (N*IA into A), DEN0 (D*IA into B),
//   ITERS rounds of ITA/ITB (A*C into A, B*C into B),
//   REM (remainder register load), and DONE (result valid).
// All control outputs are decoded from the state flops only (Moore machine).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start, abort          request a divide (IDLE only); cancel an in-flight divide
//   num_in, denom_in      32-bit operands, captured on an accepted start
//   rm_in                 rounding mode, captured on an accepted start
//   inputNum, inputDenom  registered operands presented to the datapath
//   rm                    registered rounding mode presented to the datapath
//   sel_mux4              00 N*IA, 01 D*IA, 10 A*C, 11 B*C
//   sel_mux3              00 IA, 01 C register, 10 remainder path
//   en_a, en_b, en_rem    register load enables; never more than one high at a time
//   busy                  high from NUM0 through DONE
//   done                  one-cycle pulse in DONE
//   iter                  refinement index during ITA/ITB, 0 elsewhere
`timescale 1ns/1ps
module fpdiv_ctrl #(
  parameter int ITERS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] num_in,
  input  logic [31:0] denom_in,
  input  logic        rm_in,
  output logic [31:0] inputNum,
  output logic [31:0] inputDenom,
  output logic        rm,
  output logic [1:0]  sel_mux4,
  output logic [1:0]  sel_mux3,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic        busy,
  output logic        done,
  output logic [2:0]  iter
);

  localparam logic [2:0] LAST_ITER = 3'(ITERS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM0 = 3'd1,
    S_DEN0 = 3'd2,
    S_ITA  = 3'd3,
    S_ITB  = 3'd4,
    S_REM  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       accept;
  logic       cancel;

  assign accept = (state_reg == S_IDLE) && start;

  // Abort only cancels work in progress. IDLE has nothing to cancel. DONE
  // already holds a valid result and returns to IDLE by itself.
  assign cancel = abort && (state_reg != S_IDLE) && (state_reg != S_DONE);

  // State and iteration counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Operand capture. These registers are deliberately left untouched by
  // abort, so the datapath inputs stay stable until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inputNum   <= 32'd0;
      inputDenom <= 32'd0;
      rm         <= 1'b0;
    end else if (accept) begin
      inputNum   <= num_in;
      inputDenom <= denom_in;
      rm         <= rm_in;
    end
  end

  // Next-state and counter logic. Abort wins over any forward step.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (cancel) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) state_next = S_NUM0;
        S_NUM0: state_next = S_DEN0;
        S_DEN0: begin
          state_next = S_ITA;
          cnt_next   = 3'd1;
        end
        S_ITA:  state_next = S_ITB;
        S_ITB: begin
          if (cnt_reg == LAST_ITER) begin
            state_next = S_REM;
          end else begin
            state_next = S_ITA;
            cnt_next   = cnt_reg + 3'd1;
          end
        end
        S_REM:  state_next = S_DONE;
        S_DONE: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    sel_mux4 = 2'b00;
    sel_mux3 = 2'b00;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    iter     = 3'd0;
    case (state_reg)
      S_IDLE: busy = 1'b0;
      S_NUM0: en_a = 1'b1;
      S_DEN0: begin
        sel_mux4 = 2'b01;
        en_b     = 1'b1;
      end
      S_ITA: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b01;
        en_a     = 1'b1;
        iter     = cnt_reg;
      end
      S_ITB: begin
        sel_mux4 = 2'b11;
        sel_mux3 = 2'b01;
        en_b     = 1'b1;
        iter     = cnt_reg;
      end
      S_REM: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b10;
        en_rem   = 1'b1;
      end
      S_DONE: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b10;
        done     = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
